// File: rtl/usb_pkg.sv
// Shared definitions for the RXPU token engine.
//   - PID byte values for the tokens the engine answers
//   - bit positions of the address/endpoint/CRC fields in token bytes 1 and 2
//   - FSM state and token-kind enums
//   - PID check-nibble helper
package usb_pkg;

  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_SETUP = 8'h2D;

  // byte1 = {endp[0], addr[6:0]}; byte2 = {crc5, endp[3:1]}
  localparam int B1_ADDR_LSB  = 0;
  localparam int B1_ADDR_MSB  = 6;
  localparam int B1_ENDP0_BIT = 7;
  localparam int B2_ENDP_LSB  = 0;
  localparam int B2_ENDP_MSB  = 2;
  localparam int B2_CRC_LSB   = 3;
  localparam int B2_CRC_MSB   = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_WAIT_PID,
    ST_GET_B1,
    ST_GET_B2,
    ST_CHECK_TOKEN,
    ST_DRAIN,
    ST_RESPOND
  } state_t;

  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_IN,
    KIND_OUT,
    KIND_SETUP
  } kind_t;

  // The upper nibble of a PID is the ones' complement of the lower nibble.
  function automatic logic pid_valid(input logic [7:0] pid);
    return pid[7:4] == ~pid[3:0];
  endfunction

endpackage

// File: rtl/usb_crc5.sv
// Combinational USB token CRC5 (x^5 + x^2 + 1, seed 5'b11111, complemented).
// Ports:
//   data       in  11  {endp[3:0], addr[6:0]}; bit 0 is the first bit on the wire
//   crc_field  out  5  CRC laid out as it sits in token byte2[7:3]
//                      (crc_field[0] = byte2[3] = first CRC bit transmitted)
module usb_crc5 (
  input  logic [10:0] data,
  output logic [4:0]  crc_field
);

  logic [4:0] lfsr;

  always_comb begin
    lfsr = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      lfsr = {lfsr[3:0], 1'b0} ^ ({5{lfsr[4] ^ data[i]}} & 5'b00101);
    end
    lfsr = ~lfsr;
    // The register MSB leaves the wire first, and token bytes go out LSB
    // first, so the field in byte2 is the register bit-reversed.
    crc_field = {lfsr[0], lfsr[1], lfsr[2], lfsr[3], lfsr[4]};
  end

endmodule

// File: rtl/rxpu_token_engine.sv
// Receive-side token engine: pulls PID/addr/endp/CRC bytes from the receive
// FIFO, qualifies the token, and issues a single one-cycle handshake or
// token-accepted pulse once the packet's EOP is seen.
//
// state           | meaning
// ----------------+---------------------------------------------------------
// ST_IDLE         | decide between flushing (TX busy) and waiting for a PID
// ST_FLUSH        | discard receive bytes while the TX unit is active
// ST_WAIT_PID     | wait for first byte, classify it as IN/OUT/SETUP/foreign
// ST_GET_B1       | capture addr + endp[0]
// ST_GET_B2       | capture endp[3:1] + CRC5
// ST_CHECK_TOKEN  | compare addr/CRC/endp, latch accept decision
// ST_DRAIN        | discard remaining bytes until EOP
// ST_RESPOND      | one-cycle response for an accepted token
//
// Ports:
//   clk, n_rst                  clock (rising edge), async active-low reset
//   dev_addr[6:0]               device address
//   is_tx_active                TX unit transmitting
//   is_rcv_empty, rcv_bus[7:0]  FWFT receive FIFO status / head byte
//   is_eop_rcvd                 one-cycle EOP pulse from the receiver
//   ep_ready, ep_halt           per-endpoint IN-data-available / halted
//   read_rcv_fifo               pop FIFO head
//   send_data/nak/stall         one-cycle TX handshake requests
//   out_token, setup_token      one-cycle token-accepted pulses
//   tx_ep[3:0]                  endpoint of the last accepted token
//   crc_err, timeout            one-cycle error pulses
module rxpu_token_engine
  import usb_pkg::*;
#(
  parameter int NUM_EP         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [6:0]        dev_addr,
  input  logic              is_tx_active,
  input  logic              is_rcv_empty,
  input  logic              is_eop_rcvd,
  input  logic [7:0]        rcv_bus,
  input  logic [NUM_EP-1:0] ep_ready,
  input  logic [NUM_EP-1:0] ep_halt,
  output logic              read_rcv_fifo,
  output logic              send_data,
  output logic              send_nak,
  output logic              send_stall,
  output logic              out_token,
  output logic              setup_token,
  output logic [3:0]        tx_ep,
  output logic              crc_err,
  output logic              timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t     state, next_state;
  kind_t      kind, pid_kind;
  logic [7:0] byte1, byte2;
  logic       match_q;
  logic [CNT_W-1:0] idle_cnt;

  logic [6:0]  tok_addr;
  logic [3:0]  tok_endp;
  logic [4:0]  crc_calc;
  logic        crc_ok, token_match, counting, cnt_at_limit;
  logic [15:0] ready_ext, halt_ext;

  assign tok_addr = byte1[B1_ADDR_MSB:B1_ADDR_LSB];
  assign tok_endp = {byte2[B2_ENDP_MSB:B2_ENDP_LSB], byte1[B1_ENDP0_BIT]};

  usb_crc5 u_crc5 (
    .data      ({tok_endp, tok_addr}),
    .crc_field (crc_calc)
  );

  assign crc_ok      = (crc_calc == byte2[B2_CRC_MSB:B2_CRC_LSB]);
  assign token_match = (tok_addr == dev_addr) && crc_ok &&
                       ({1'b0, tok_endp} < 5'(NUM_EP));

  // Widened so tx_ep can index any endpoint count without a width mismatch;
  // tx_ep is always < NUM_EP when used.
  assign ready_ext = 16'(ep_ready);
  assign halt_ext  = 16'(ep_halt);

  assign counting     = (state == ST_GET_B1) || (state == ST_GET_B2) ||
                        (state == ST_DRAIN);
  assign cnt_at_limit = (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    pid_kind = KIND_NONE;
    if (pid_valid(rcv_bus)) begin
      case (rcv_bus)
        PID_IN:    pid_kind = KIND_IN;
        PID_OUT:   pid_kind = KIND_OUT;
        PID_SETUP: pid_kind = KIND_SETUP;
        default:   pid_kind = KIND_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    read_rcv_fifo = 1'b0;
    send_data     = 1'b0;
    send_nak      = 1'b0;
    send_stall    = 1'b0;
    out_token     = 1'b0;
    setup_token   = 1'b0;
    crc_err       = 1'b0;
    timeout       = 1'b0;
    case (state)
      ST_IDLE: begin
        next_state = is_tx_active ? ST_FLUSH : ST_WAIT_PID;
      end
      ST_FLUSH: begin
        read_rcv_fifo = ~is_rcv_empty;
        if (!is_tx_active) next_state = ST_IDLE;
      end
      ST_WAIT_PID: begin
        if (!is_rcv_empty) begin
          read_rcv_fifo = 1'b1;
          next_state    = (pid_kind == KIND_NONE) ? ST_DRAIN : ST_GET_B1;
        end
      end
      ST_GET_B1, ST_GET_B2: begin
        // EOP before the token is complete is a short packet: drop silently.
        if (is_eop_rcvd) begin
          next_state = ST_IDLE;
        end else if (!is_rcv_empty) begin
          read_rcv_fifo = 1'b1;
          next_state    = (state == ST_GET_B1) ? ST_GET_B2 : ST_CHECK_TOKEN;
        end else if (cnt_at_limit) begin
          timeout    = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_CHECK_TOKEN: begin
        crc_err    = ~crc_ok;
        next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        read_rcv_fifo = ~is_rcv_empty;
        if (is_eop_rcvd) begin
          next_state = match_q ? ST_RESPOND : ST_IDLE;
        end else if (is_rcv_empty && cnt_at_limit) begin
          timeout    = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_RESPOND: begin
        case (kind)
          KIND_IN: begin
            if (halt_ext[tx_ep])       send_stall = 1'b1;
            else if (ready_ext[tx_ep]) send_data  = 1'b1;
            else                       send_nak   = 1'b1;
          end
          KIND_OUT:   out_token   = 1'b1;
          KIND_SETUP: setup_token = 1'b1;
          default: ;
        endcase
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idle_cnt <= '0;
      kind     <= KIND_NONE;
      byte1    <= '0;
      byte2    <= '0;
      match_q  <= 1'b0;
      tx_ep    <= '0;
    end else begin
      if (read_rcv_fifo || !counting) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (state == ST_WAIT_PID) begin
        match_q <= 1'b0;
        if (read_rcv_fifo) kind <= pid_kind;
      end
      if (state == ST_GET_B1 && read_rcv_fifo) byte1 <= rcv_bus;
      if (state == ST_GET_B2 && read_rcv_fifo) byte2 <= rcv_bus;

      if (state == ST_CHECK_TOKEN) begin
        match_q <= token_match;
        if (token_match) tx_ep <= tok_endp;
      end
    end
  end

endmodule
